ped_crossing_ctrl: RTL and testbench
====================================

Name: ped_crossing_ctrl

Overview:
- Downstream consumer of the north-south light code `light_ns`. That code is 2 bits: 00 = RED, 01 = GREEN, 10 = YELLOW, 11 = illegal.
- Latches pedestrian button requests and grants a WALK phase for crossing the NS road only at the start of an NS RED phase.
- After WALK, runs a flashing DON'T WALK phase with a countdown display.
- Forces pedestrians to DON'T WALK and flags a sticky fault if the light leaves RED while a crossing is active.

Parameters:
- WALK_CYCLES, 4: cycles of steady WALK. Legal range 1..15.
- FLASH_CYCLES, 3: cycles of flashing DON'T WALK with countdown. Legal range 1..15.
- Integration rule: 1 + WALK_CYCLES + FLASH_CYCLES ≤ 9, the NS RED dwell of the upstream sequencer.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- light_ns  input  2  NS light code from the upstream sequencer; synchronous to clk.
- ped_btn  input  1  pedestrian button level, already synchronous to clk.
- walk  output  1  steady WALK lamp.
- dont_walk  output  1  DON'T WALK lamp; steady or flashing.
- countdown  output  4  remaining flash cycles; 0 when not flashing.
- req_pending  output  1  a request is latched and waiting.
- fault  output  1  sticky safety violation flag.

Behaviour:
- Reset values (asynchronous, while reset_n = 0):
  - state = IDLE, walk = 0, dont_walk = 1, countdown = 0, req_pending = 0, fault = 0.
  - btn_q = 0, light_q = RED.
- Edge detectors, evaluated every cycle:
  - btn_rise = ped_btn & ~btn_q.
  - red_entry = (light_ns == 00) & (light_q != 00).
  - light_q and btn_q register light_ns and ped_btn each cycle.
  - Because light_q resets to RED, a RED held from reset produces no red_entry.
- req_pending:
  - Set on btn_rise in IDLE or FLASH.
  - btn_rise during WALK is ignored; that request is already being served.
  - Cleared on the IDLE→WALK transition.
  - If btn_rise and the IDLE→WALK transition coincide, the clear wins and req_pending = 0.
- State machine (registered; outputs decoded from registered state):
  - IDLE:
    - walk = 0, dont_walk = 1, countdown = 0.
    - If red_entry & req_pending: go to WALK and load the counter with WALK_CYCLES.
    - A request set in the same cycle as red_entry does not qualify; it waits for the next red_entry.
  - WALK:
    - walk = 1, dont_walk = 0.
    - Counter decrements each cycle.
    - In the cycle the counter equals 1: go to FLASH and load the counter with FLASH_CYCLES.
    - Total WALK dwell is exactly WALK_CYCLES cycles.
  - FLASH:
    - walk = 0. dont_walk = 1 in the first FLASH cycle, then toggles every cycle.
    - countdown = counter value: FLASH_CYCLES on the first cycle, 1 on the last.
    - In the cycle the counter equals 1: go to IDLE. Dwell is exactly FLASH_CYCLES cycles.
- Latency:
  - walk rises on the first clk edge after the cycle light_ns first reads RED.
  - WALK is granted only if req_pending was already 1 in that cycle.
- Safety abort:
  - Trigger: in WALK or FLASH, light_ns != 00 in any cycle.
  - Next edge: state = IDLE, walk = 0, dont_walk = 1, countdown = 0, fault = 1.
  - req_pending is unchanged.
- Illegal code 11:
  - Treated as not-RED for both abort and red_entry.
  - Seen in IDLE, it also sets fault.
- fault is cleared only by reset_n.
- Simultaneous abort and normal expiry: abort wins and fault is set.
- Reset asserted mid-WALK or mid-FLASH: outputs return to reset values immediately (asynchronous), with no glitch of walk to 1.
- Counter is 4 bits and never wraps; it is always reloaded before it reaches 0.

Test Plan:
- Basic grant:
  - Stimulus: reset, drive light_ns GREEN→YELLOW→RED; pulse ped_btn during GREEN.
  - Response: req_pending = 1. On the edge after RED first appears: walk = 1 for 4 cycles, req_pending = 0.
  - Then dont_walk reads 1,0,1 with countdown 3,2,1, then IDLE with countdown = 0.
- No request:
  - Stimulus: full RED phase with ped_btn held low.
  - Response: walk stays 0, dont_walk stays 1, countdown stays 0.
- Late and ignored presses:
  - Stimulus: press arriving mid-RED after red_entry.
  - Response: no WALK this phase; WALK on the next RED entry.
  - Stimulus: press during WALK.
  - Response: req_pending stays 0.
- Held button:
  - Stimulus: ped_btn held high for 20 cycles across phases.
  - Response: exactly one request latched.
- Safety abort:
  - Stimulus: force light_ns to GREEN in the 2nd WALK cycle.
  - Response: next edge walk = 0, dont_walk = 1, fault = 1. fault persists through later normal phases.
- Illegal code and reset:
  - Stimulus: light_ns = 11 in IDLE.
  - Response: fault = 1, no WALK.
  - Stimulus: assert reset_n low mid-FLASH.
  - Response: immediately walk = 0, dont_walk = 1, countdown = 0, fault = 0, req_pending = 0.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller for the north-south road: latches button
// requests, grants WALK at the start of an NS RED phase, then a counted flash.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYCLES  = 4,
  parameter int unsigned FLASH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] light_ns,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    FLASH = 2'b10
  } state_t;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;
  localparam logic [3:0] WALK_LOAD     = 4'(WALK_CYCLES);
  localparam logic [3:0] FLASH_LOAD    = 4'(FLASH_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic [3:0] count_next;
  logic       flash_on;
  logic       flash_on_next;
  logic       req_next;
  logic       fault_next;
  logic       btn_q;
  logic [1:0] light_q;

  logic       btn_rise;
  logic       not_red;
  logic       red_entry;
  logic       abort;
  logic       grant;

  // Illegal code 11 counts as not-RED for both the abort check and red_entry.
  assign not_red   = (light_ns != LIGHT_RED);
  assign btn_rise  = ped_btn & ~btn_q;
  assign red_entry = ~not_red & (light_q != LIGHT_RED);
  assign abort     = (state != IDLE) & not_red;
  assign grant     = (state == IDLE) & red_entry & req_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= 4'd0;
      flash_on    <= 1'b0;
      req_pending <= 1'b0;
      fault       <= 1'b0;
      btn_q       <= 1'b0;
      light_q     <= LIGHT_RED;
    end else begin
      state       <= state_next;
      count       <= count_next;
      flash_on    <= flash_on_next;
      req_pending <= req_next;
      fault       <= fault_next;
      btn_q       <= ped_btn;
      light_q     <= light_ns;
    end
  end

  // The counter is always reloaded on the cycle it reads 1, so it never wraps.
  always_comb begin
    state_next    = state;
    count_next    = count;
    flash_on_next = flash_on;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = WALK;
          count_next = WALK_LOAD;
        end
      end
      WALK: begin
        if (abort) begin
          state_next = IDLE;
          count_next = 4'd0;
        end else if (count == 4'd1) begin
          state_next    = FLASH;
          count_next    = FLASH_LOAD;
          flash_on_next = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      FLASH: begin
        if (abort || (count == 4'd1)) begin
          state_next    = IDLE;
          count_next    = 4'd0;
          flash_on_next = 1'b0;
        end else begin
          count_next    = count - 4'd1;
          flash_on_next = ~flash_on;
        end
      end
      default: begin
        state_next    = IDLE;
        count_next    = 4'd0;
        flash_on_next = 1'b0;
      end
    endcase
  end

  // A grant clears the request even if a fresh press lands in the same cycle.
  always_comb begin
    req_next = req_pending;
    if (grant) begin
      req_next = 1'b0;
    end else if (btn_rise && (state != WALK)) begin
      req_next = 1'b1;
    end
    fault_next = fault | abort | ((state == IDLE) & (light_ns == LIGHT_ILLEGAL));
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    countdown = 4'd0;
    case (state)
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      FLASH: begin
        dont_walk = flash_on;
        countdown = count;
      end
      default: begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        countdown = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: a phase-level reference model predicts
// every cycle's outputs, and a monitor compares them one cycle later.
module tb_ped_crossing_ctrl;

  localparam int W = 4;
  localparam int F = 3;
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] light_ns = RED;
  logic       ped_btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic [3:0] countdown;
  logic       req_pending;
  logic       fault;

  ped_crossing_ctrl #(.WALK_CYCLES(W), .FLASH_CYCLES(F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .light_ns   (light_ns),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .countdown  (countdown),
    .req_pending(req_pending),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       req;
    logic       fault;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: remaining walk / flash cycles as plain integers.
  int         walk_left = 0;
  int         flash_left = 0;
  bit         m_req = 0;
  bit         m_fault = 0;
  logic [1:0] prev_light = RED;
  bit         prev_btn = 0;
  bit         btn_level = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    walk_left  = 0;
    flash_left = 0;
    m_req      = 0;
    m_fault    = 0;
    prev_light = RED;
    prev_btn   = 0;
  endtask

  task automatic model_step(input logic [1:0] light, input bit btn, output exp_t e);
    bit active, rise, rentry, abort_now, grant_now;
    active    = (walk_left > 0) || (flash_left > 0);
    rise      = btn && !prev_btn;
    rentry    = (light == RED) && (prev_light != RED);
    abort_now = active && (light != RED);
    grant_now = !active && rentry && m_req;
    if (grant_now) m_req = 0;
    else if (rise && walk_left == 0) m_req = 1;
    if (abort_now || (!active && light == BAD)) m_fault = 1;
    if (abort_now) begin
      walk_left  = 0;
      flash_left = 0;
    end else if (grant_now) begin
      walk_left = W;
    end else if (walk_left > 0) begin
      walk_left--;
      if (walk_left == 0) flash_left = F;
    end else if (flash_left > 0) begin
      flash_left--;
    end
    prev_light  = light;
    prev_btn    = btn;
    e.walk      = (walk_left > 0);
    e.dont_walk = (walk_left > 0) ? 1'b0 : (flash_left > 0) ? (((F - flash_left) % 2) == 0) : 1'b1;
    e.countdown = 4'(flash_left);
    e.req       = m_req;
    e.fault     = m_fault;
  endtask

  // Called at a falling edge: drive one cycle, predict, then wait a full cycle.
  task automatic applyStimulus(input logic [1:0] light, input bit btn);
    exp_t e;
    light_ns = light;
    ped_btn  = btn;
    model_step(light, btn, e);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_phase(input logic [1:0] code, input int n, input int press_at, input bit hold);
    for (int i = 0; i < n; i++) applyStimulus(code, hold || (i == press_at));
  endtask

  task automatic run_random_phase(input logic [1:0] code, input int n);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 20) btn_level = ~btn_level;
      c = code;
      if ($urandom_range(0, 99) < 3) c = 2'($urandom_range(1, 3));
      applyStimulus(c, btn_level);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    light_ns = RED;
    ped_btn  = 1'b0;
    #1;
    checkOutput("reset_walk", walk, 0);
    checkOutput("reset_dont_walk", dont_walk, 1);
    checkOutput("reset_countdown", countdown, 0);
    checkOutput("reset_req_pending", req_pending, 0);
    checkOutput("reset_fault", fault, 0);
    model_reset();
    btn_level = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every cycle out of reset the DUT presents a full output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("walk", walk, e.walk);
        checkOutput("dont_walk", dont_walk, e.dont_walk);
        checkOutput("countdown", countdown, e.countdown);
        checkOutput("req_pending", req_pending, e.req);
        checkOutput("fault", fault, e.fault);
      end
    end
  end

  initial begin
    int guard;
    $display("[TB] starting ped_crossing_ctrl bench");
    repeat (2) @(negedge clk);
    do_reset();

    // Basic grant, then a phase with no request.
    run_phase(GREEN, 6, 2, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, -1, 0);
    run_phase(GREEN, 4, -1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, -1, 0);
    run_phase(GREEN, 4, -1, 0);

    // Late press mid-RED waits for the next RED entry.
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, 3, 0);
    run_phase(GREEN, 4, -1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, -1, 0);

    // Press during WALK is ignored.
    run_phase(GREEN, 4, 1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, 2, 0);
    run_phase(GREEN, 4, -1, 0);

    // Held button across 20 cycles latches one request only.
    run_phase(YELLOW, 3, -1, 0);
    run_phase(GREEN, 8, -1, 1);
    run_phase(YELLOW, 3, -1, 1);
    run_phase(RED, 9, -1, 1);
    run_phase(GREEN, 4, -1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, -1, 0);
    run_phase(GREEN, 3, -1, 0);

    // Safety abort in the second WALK cycle; fault stays sticky.
    do_reset();
    run_phase(GREEN, 4, 1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 2, -1, 0);
    run_phase(GREEN, 5, -1, 0);
    run_phase(YELLOW, 3, -1, 0);
    run_phase(RED, 9, -1, 0);
    run_phase(GREEN, 3, -1, 0);

    // Illegal code in IDLE.
    do_reset();
    run_phase(GREEN, 3, -1, 0);
    run_phase(BAD, 1, -1, 0);
    run_phase(RED, 9, -1, 0);
    run_phase(GREEN, 3, -1, 0);

    // Reset mid-FLASH, with a request latched during FLASH.
    do_reset();
    run_phase(GREEN, 3, 1, 0);
    run_phase(YELLOW, 2, -1, 0);
    guard = 0;
    while (flash_left != 2 && guard < 40) begin
      applyStimulus(RED, flash_left == F);
      guard++;
    end
    checkOutput("mid_flash_countdown", countdown, 2);
    checkOutput("mid_flash_req_pending", req_pending, 1);
    do_reset();

    // Randomised traffic phases with occasional corrupted light codes.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int ph = 0; ph < 4; ph++) begin
        run_random_phase(GREEN, $urandom_range(3, 8));
        run_random_phase(YELLOW, $urandom_range(2, 4));
        run_random_phase(RED, 9);
      end
    end

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
